regfile_wport_arbiter: RTL and testbench
========================================

Name: regfile_wport_arbiter

Overview:
- Round-robin arbiter that shares the two write ports of the 2-write/1-read synchronous register file RAM among NUM_REQ writeback requesters.
- Each cycle it grants up to two requests and launches them through registered write-port outputs that connect directly to the RAM's we1/waddr1/wdata1/we2/waddr2/wdata2.
- It never issues two writes to the same address in one cycle, so the RAM's same-address port-2 priority rule is never exercised.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_WIDTH, 5, register file address width.
- DATA_WIDTH, 32, register file data width.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset (asserted at 0).
- en  input  1  arbitration enable; 0 = no grants this cycle.
- req_valid  input  NUM_REQ  per-requester write request.
- req_addr  input  NUM_REQ*ADDR_WIDTH  packed addresses; requester i uses bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_data  input  NUM_REQ*DATA_WIDTH  packed data; requester i uses bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  output  NUM_REQ  grant; a transfer occurs when valid&ready.
- we1  output  1  RAM write port 1 enable (registered).
- waddr1  output  ADDR_WIDTH  RAM write port 1 address (registered).
- wdata1  output  DATA_WIDTH  RAM write port 1 data (registered).
- we2  output  1  RAM write port 2 enable (registered).
- waddr2  output  ADDR_WIDTH  RAM write port 2 address (registered).
- wdata2  output  DATA_WIDTH  RAM write port 2 data (registered).
- busy  output  1  1 when we1|we2 is currently driven.
- conflict  output  1  registered pulse: an otherwise grantable second request was held back by an address match last cycle.

Behaviour:
- Reset (rst=0, asynchronous):
  - rr_ptr=0; we1=we2=0; waddr1/2=0; wdata1/2=0; conflict=0.
  - req_ready=0 while reset is asserted.
- Handshake:
  - req_ready is combinational from req_valid, req_addr, rr_ptr and en.
  - Requesters must not make req_valid depend on req_ready.
  - A held request keeps its addr and data stable until granted.
- Selection (en=1):
  - Scan indices rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - Slot A = first valid requester.
  - Slot B = next valid requester after A whose address differs from A's.
  - A valid requester between A and B with addr==A's addr is skipped. It sets conflict_next=1.
  - req_ready is 1 only for A and B.
- Launch latency is 1 cycle:
  - Slot A registers into we1/waddr1/wdata1.
  - Slot B registers into we2/waddr2/wdata2.
  - An empty slot registers we=0. Its addr/data hold their previous values.
  - Only A granted: we1=1, we2=0.
  - None granted: we1=we2=0.
- rr_ptr update:
  - After any grant, rr_ptr = (index of last granted slot + 1) mod NUM_REQ.
  - With no grant, rr_ptr holds.
  - This guarantees every persistent requester is granted within ceil(NUM_REQ/2) granting cycles, absent address conflicts.
  - A conflicted requester is reached no later than the following granting cycle.
- en=0:
  - req_ready=0 for all requesters.
  - we1=we2=0 next cycle; rr_ptr holds; conflict=0.
- Wrap-around: the scan crosses from NUM_REQ-1 to 0 seamlessly. Example: rr_ptr=3 with NUM_REQ=4 scans 3,0,1,2.
- Single requester valid: granted alone on port 1, never on port 2.
- busy = we1|we2 (registered state, no combinational path from inputs).
- Reset asserted mid-operation:
  - Outputs clear immediately.
  - Any launched-but-unwritten write is dropped. The RAM captures nothing at the next edge because we1=we2=0.

Test Plan:
- Reset: hold rst=0 with req_valid=4'b1111 -> req_ready=0, we1=we2=0, busy=0; release, en=1 -> next cycle we1=we2=1.
- Round-robin: all four valid, addrs 1,2,3,4, data 0xA0..0xA3, en=1 continuously.
  - Cycle 0 grants 0,1 -> we1 addr1/0xA0, we2 addr2/0xA1.
  - Cycle 1 grants 2,3 -> addr3/0xA2 and addr4/0xA3.
  - rr_ptr returns to 0.
- Address conflict: req0 and req1 both addr 5, req2 addr 6, rr_ptr=0.
  - Grants are 0 and 2 -> waddr1=5, waddr2=6, conflict=1 next cycle.
  - req1 is granted the following cycle on port 1.
- Wrap: force rr_ptr=3 via prior traffic; only req3 and req0 valid -> req3 on port 1, req0 on port 2, rr_ptr=1.
- en=0 with all valid for 3 cycles -> req_ready=0, we1=we2=0, rr_ptr unchanged; en=1 resumes from the same rr_ptr.
- Integration with the 2w1r RAM: write addr 7=0x1234 via one requester, then read addr 7 -> rdata=0x1234; random 10k-cycle traffic against a reference model shows no same-cycle same-address writes (waddr1!=waddr2 whenever we1&we2) and no lost or duplicated writes.

Source files
------------

// File: rtl/regfile_wport_arbiter.sv
// regfile_wport_arbiter: round-robin arbiter that shares the two write ports of a 2w1r register file.
// Each cycle it grants up to two requesters with distinct addresses and launches them through registered ports.
module regfile_wport_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           we1,
    output logic [ADDR_WIDTH-1:0]          waddr1,
    output logic [DATA_WIDTH-1:0]          wdata1,
    output logic                           we2,
    output logic [ADDR_WIDTH-1:0]          waddr2,
    output logic [DATA_WIDTH-1:0]          wdata2,
    output logic                           busy,
    output logic                           conflict
);
    localparam int IW = $clog2(NUM_REQ);

    logic [IW-1:0]         r_ptr;
    logic [IW-1:0]         w_idx;
    logic [IW:0]           w_sum;
    logic [IW-1:0]         w_a_idx;
    logic [IW-1:0]         w_b_idx;
    logic [IW-1:0]         w_last;
    logic [IW-1:0]         w_next;
    logic                  w_a_found;
    logic                  w_b_found;
    logic                  w_conf;
    logic [ADDR_WIDTH-1:0] w_a_addr;
    logic [NUM_REQ-1:0]    w_ready;

    // Scan from r_ptr with wrap; a same-address requester after slot A is held back.
    always_comb begin
        w_a_found = 1'b0;
        w_b_found = 1'b0;
        w_a_idx   = '0;
        w_b_idx   = '0;
        w_conf    = 1'b0;
        w_a_addr  = '0;
        w_sum     = '0;
        w_idx     = '0;
        w_ready   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, r_ptr} + (IW+1)'(k);
            w_idx = (w_sum >= (IW+1)'(NUM_REQ)) ? IW'(w_sum - (IW+1)'(NUM_REQ)) : w_sum[IW-1:0];
            if (en && req_valid[w_idx]) begin
                if (!w_a_found) begin
                    w_a_found = 1'b1;
                    w_a_idx   = w_idx;
                    w_a_addr  = req_addr[w_idx*ADDR_WIDTH +: ADDR_WIDTH];
                end else if (!w_b_found) begin
                    if (req_addr[w_idx*ADDR_WIDTH +: ADDR_WIDTH] == w_a_addr) begin
                        w_conf = 1'b1;
                    end else begin
                        w_b_found = 1'b1;
                        w_b_idx   = w_idx;
                    end
                end
            end
        end
        if (w_a_found) w_ready[w_a_idx] = 1'b1;
        if (w_b_found) w_ready[w_b_idx] = 1'b1;
    end

    assign req_ready = rst ? w_ready : '0;
    assign w_last    = w_b_found ? w_b_idx : w_a_idx;
    assign w_next    = (w_last == IW'(NUM_REQ-1)) ? '0 : w_last + 1'b1;
    assign busy      = we1 | we2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr    <= '0;
            we1      <= 1'b0;
            waddr1   <= '0;
            wdata1   <= '0;
            we2      <= 1'b0;
            waddr2   <= '0;
            wdata2   <= '0;
            conflict <= 1'b0;
        end else begin
            we1      <= w_a_found;
            we2      <= w_b_found;
            conflict <= w_conf;
            if (w_a_found) begin
                waddr1 <= req_addr[w_a_idx*ADDR_WIDTH +: ADDR_WIDTH];
                wdata1 <= req_data[w_a_idx*DATA_WIDTH +: DATA_WIDTH];
                r_ptr  <= w_next;
            end
            if (w_b_found) begin
                waddr2 <= req_addr[w_b_idx*ADDR_WIDTH +: ADDR_WIDTH];
                wdata2 <= req_data[w_b_idx*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end
endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// tb_regfile_wport_arbiter: directed vector table, reset corners and random traffic against a queue-based model.
module tb_regfile_wport_arbiter;
    localparam int N  = 4;
    localparam int AW = 5;
    localparam int DW = 32;

    logic              clk, rst, en;
    logic [N-1:0]      req_valid, req_ready;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_data;
    logic              we1, we2, busy, conflict;
    logic [AW-1:0]     waddr1, waddr2;
    logic [DW-1:0]     wdata1, wdata2;

    int n_pass = 0;
    int n_tot  = 0;

    regfile_wport_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .en(en), .req_valid(req_valid), .req_addr(req_addr),
        .req_data(req_data), .req_ready(req_ready), .we1(we1), .waddr1(waddr1),
        .wdata1(wdata1), .we2(we2), .waddr2(waddr2), .wdata2(wdata2),
        .busy(busy), .conflict(conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file RAM fed by the arbiter, port 2 wins on a same-address write.
    logic [DW-1:0] mem [32];
    logic [DW-1:0] ref_mem [32];
    initial for (int i = 0; i < 32; i++) begin mem[i] = '0; ref_mem[i] = '0; end
    always @(posedge clk) begin
        if (we1) mem[waddr1] <= wdata1;
        if (we2) mem[waddr2] <= wdata2;
    end

    typedef struct {
        logic          en;
        logic [N-1:0]  v;
        logic [N*AW-1:0] a;
        logic [N*DW-1:0] d;
        logic [N-1:0]  rdy;
        logic          we1;
        logic [AW-1:0] wa1;
        logic [DW-1:0] wd1;
        logic          we2;
        logic [AW-1:0] wa2;
        logic [DW-1:0] wd2;
        logic          cf;
    } vec_t;
    vec_t tbl [14];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [N*AW-1:0] pa(input int a0, input int a1, input int a2, input int a3);
        return {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
    endfunction

    function automatic logic [N*DW-1:0] pd(input int d0, input int d1, input int d2, input int d3);
        return {DW'(d3), DW'(d2), DW'(d1), DW'(d0)};
    endfunction

    task automatic cycle(input logic e, input logic [N-1:0] v, input logic [N*AW-1:0] a,
                         input logic [N*DW-1:0] d, output logic [N-1:0] rdy);
        en = e; req_valid = v; req_addr = a; req_data = d;
        @(negedge clk);
        rdy = req_ready;
        @(posedge clk);
        #1;
    endtask

    // Reference: ordered list of valid requesters starting at ptr; A = head, B = first later one with a new address.
    function automatic void model(input logic e, input logic [N-1:0] v, input logic [N*AW-1:0] a,
                                  input int ptr, output int ga, output int gb, output bit cf);
        int order[$];
        ga = -1; gb = -1; cf = 0;
        if (!e) return;
        for (int k = 0; k < N; k++) if (v[(ptr + k) % N]) order.push_back((ptr + k) % N);
        if (order.size() == 0) return;
        ga = order[0];
        for (int j = 1; j < order.size(); j++) begin
            if (a[order[j]*AW +: AW] != a[ga*AW +: AW]) begin gb = order[j]; break; end
            cf = 1;
        end
    endfunction

    logic [N-1:0]    rdy;
    logic [N*AW-1:0] A1234;
    logic [N*DW-1:0] D;

    logic [N-1:0]    pv;
    logic [AW-1:0]   paddr [N];
    logic [DW-1:0]   pdata [N];
    logic [N*AW-1:0] ra;
    logic [N*DW-1:0] rd;
    logic [N-1:0]    m_rdy;
    logic            m_we1, m_we2, m_cf, re;
    logic [AW-1:0]   m_wa1, m_wa2;
    logic [DW-1:0]   m_wd1, m_wd2;
    int              m_ptr, ga, gb, serial;
    bit              cf;

    task automatic rand_cycle(input int cyc, input bit allow_new);
        for (int i = 0; i < N; i++)
            if (!pv[i] && allow_new && $urandom_range(0, 1) == 1) begin
                pv[i] = 1'b1; paddr[i] = AW'(16 + $urandom_range(0, 7)); pdata[i] = DW'(serial); serial++;
            end
        for (int i = 0; i < N; i++) begin ra[i*AW +: AW] = paddr[i]; rd[i*DW +: DW] = pdata[i]; end
        re = allow_new ? ($urandom_range(0, 9) != 0) : 1'b1;
        model(re, pv, ra, m_ptr, ga, gb, cf);
        m_rdy = '0;
        m_we1 = (ga >= 0); m_we2 = (gb >= 0); m_cf = cf;
        if (ga >= 0) begin m_rdy[ga] = 1'b1; m_wa1 = paddr[ga]; m_wd1 = pdata[ga]; ref_mem[paddr[ga]] = pdata[ga]; end
        if (gb >= 0) begin m_rdy[gb] = 1'b1; m_wa2 = paddr[gb]; m_wd2 = pdata[gb]; ref_mem[paddr[gb]] = pdata[gb]; end
        m_ptr = (gb >= 0) ? (gb + 1) % N : (ga >= 0) ? (ga + 1) % N : m_ptr;
        cycle(re, pv, ra, rd, rdy);
        chk($sformatf("rnd%0d ready", cyc), 64'(rdy), 64'(m_rdy));
        chk($sformatf("rnd%0d port", cyc), {we1, we2, conflict, waddr1, waddr2, wdata1[15:0], wdata2[15:0]},
            {m_we1, m_we2, m_cf, m_wa1, m_wa2, m_wd1[15:0], m_wd2[15:0]});
        if (we1 && we2) chk($sformatf("rnd%0d distinct addr", cyc), 64'(waddr1 != waddr2), 64'd1);
        if (ga >= 0) pv[ga] = 1'b0;
        if (gb >= 0) pv[gb] = 1'b0;
    endtask

    initial begin
        A1234 = pa(1, 2, 3, 4);
        D     = pd('hA0, 'hA1, 'hA2, 'hA3);
        tbl[0]  = '{1'b1, 4'b1111, A1234, D, 4'b0011, 1'b1, 5'd1, 32'hA0, 1'b1, 5'd2, 32'hA1, 1'b0};
        tbl[1]  = '{1'b1, 4'b1111, A1234, D, 4'b1100, 1'b1, 5'd3, 32'hA2, 1'b1, 5'd4, 32'hA3, 1'b0};
        tbl[2]  = '{1'b1, 4'b0111, pa(5, 5, 6, 0), D, 4'b0101, 1'b1, 5'd5, 32'hA0, 1'b1, 5'd6, 32'hA2, 1'b1};
        tbl[3]  = '{1'b1, 4'b0010, pa(5, 5, 6, 0), D, 4'b0010, 1'b1, 5'd5, 32'hA1, 1'b0, 5'd6, 32'hA2, 1'b0};
        tbl[4]  = '{1'b1, 4'b0100, pa(0, 0, 9, 0), D, 4'b0100, 1'b1, 5'd9, 32'hA2, 1'b0, 5'd6, 32'hA2, 1'b0};
        tbl[5]  = '{1'b1, 4'b1001, A1234, D, 4'b1001, 1'b1, 5'd4, 32'hA3, 1'b1, 5'd1, 32'hA0, 1'b0};
        for (int i = 6; i < 9; i++)
            tbl[i] = '{1'b0, 4'b1111, A1234, D, 4'b0000, 1'b0, 5'd4, 32'hA3, 1'b0, 5'd1, 32'hA0, 1'b0};
        tbl[9]  = '{1'b1, 4'b1111, A1234, D, 4'b0110, 1'b1, 5'd2, 32'hA1, 1'b1, 5'd3, 32'hA2, 1'b0};
        tbl[10] = '{1'b1, 4'b1111, A1234, D, 4'b1001, 1'b1, 5'd4, 32'hA3, 1'b1, 5'd1, 32'hA0, 1'b0};
        tbl[11] = '{1'b1, 4'b0000, A1234, D, 4'b0000, 1'b0, 5'd4, 32'hA3, 1'b0, 5'd1, 32'hA0, 1'b0};
        tbl[12] = '{1'b1, 4'b0001, pa(7, 0, 0, 0), pd('h1234, 0, 0, 0), 4'b0001, 1'b1, 5'd7, 32'h1234, 1'b0, 5'd1, 32'hA0, 1'b0};
        tbl[13] = '{1'b1, 4'b0011, pa(8, 8, 0, 0), D, 4'b0010, 1'b1, 5'd8, 32'hA1, 1'b0, 5'd1, 32'hA0, 1'b1};

        rst = 1'b0; en = 1'b1; req_valid = 4'b1111; req_addr = A1234; req_data = D;
        #12;
        chk("reset ready", 64'(req_ready), 64'd0);
        chk("reset we", {we1, we2, busy, conflict}, 64'd0);
        chk("reset waddr/wdata", {waddr1, waddr2, wdata1[15:0], wdata2[15:0]}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        for (int i = 0; i < 14; i++) begin
            cycle(tbl[i].en, tbl[i].v, tbl[i].a, tbl[i].d, rdy);
            chk($sformatf("vec%0d ready", i), 64'(rdy), 64'(tbl[i].rdy));
            chk($sformatf("vec%0d we1", i), 64'(we1), 64'(tbl[i].we1));
            chk($sformatf("vec%0d waddr1", i), 64'(waddr1), 64'(tbl[i].wa1));
            chk($sformatf("vec%0d wdata1", i), 64'(wdata1), 64'(tbl[i].wd1));
            chk($sformatf("vec%0d we2", i), 64'(we2), 64'(tbl[i].we2));
            chk($sformatf("vec%0d waddr2", i), 64'(waddr2), 64'(tbl[i].wa2));
            chk($sformatf("vec%0d wdata2", i), 64'(wdata2), 64'(tbl[i].wd2));
            chk($sformatf("vec%0d conflict", i), 64'(conflict), 64'(tbl[i].cf));
            chk($sformatf("vec%0d busy", i), 64'(busy), 64'(tbl[i].we1 | tbl[i].we2));
        end
        chk("ram addr7 readback", 64'(mem[7]), 64'h1234);

        cycle(1'b1, 4'b0001, pa(10, 0, 0, 0), pd('hDEAD, 0, 0, 0), rdy);
        chk("abort launched we1", 64'(we1), 64'd1);
        req_valid = '0;
        #1 rst = 1'b0;
        #1;
        chk("abort outputs cleared", {we1, we2, busy, conflict}, 64'd0);
        chk("abort addr/data cleared", {waddr1, wdata1}, 64'd0);
        @(posedge clk); #1;
        chk("abort ram untouched", 64'(mem[10]), 64'd0);
        rst = 1'b1;

        pv = '0; m_ptr = 0; serial = 32'h1000_0000;
        m_wa1 = '0; m_wa2 = '0; m_wd1 = '0; m_wd2 = '0;
        for (int i = 0; i < N; i++) begin paddr[i] = '0; pdata[i] = '0; end
        for (int c = 0; c < 10000; c++) rand_cycle(c, 1'b1);
        for (int c = 0; c < 4; c++) rand_cycle(10000 + c, 1'b0);
        chk("drain pending", 64'(pv), 64'd0);
        for (int i = 16; i < 24; i++) chk($sformatf("ram[%0d]", i), 64'(mem[i]), 64'(ref_mem[i]));

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
